latch_decode_rr_fifo: RTL
=========================

Name: latch_decode_rr_fifo

Overview:
- Parametrised decode→register-read pipeline buffer; successor of the single-entry decode/RR latch.
- Holds up to DEPTH decoded instructions in a circular FIFO with valid/ready handshakes on both sides.
- Keeps the two-level flush (P1 overrides lock, P2 yields to lock), the global lock, and exception squashing of instruction and control fields.
- Sits between the decoder and the register-read stage; lets decode run ahead while RR is stalled.

Parameters:
- ADDR_W, 40, PC width
- INST_W, 32, instruction word width
- CTRL_W, 16, control-signal bundle width
- CAUSE_W, 64, exception cause width
- DEPTH, 2, FIFO entries; power of two, legal values 2..16
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low
- LOCK  in  1  global stall; freezes all state
- FLUSH_P1  in  1  high-priority flush; acts even under LOCK
- FLUSH_P2  in  1  low-priority flush; ignored while LOCK=1
- IN_VALID  in  1  decode presents an entry
- IN_READY  out  1  buffer accepts an entry; = !full && !LOCK
- PC_IN  in  ADDR_W  decode PC
- INST_IN  in  INST_W  decode instruction
- CTRL_IN  in  CTRL_W  decode control signals
- XCPT_IN  in  1  decode exception
- XCPT_CAUSE_IN  in  CAUSE_W  decode exception cause
- OUT_VALID  out  1  head entry valid; = !empty
- OUT_READY  in  1  RR consumes the head entry
- PC_OUT  out  ADDR_W  head PC
- INST_OUT  out  INST_W  head instruction
- CTRL_OUT  out  CTRL_W  head control signals
- XCPT_OUT  out  1  head exception flag
- XCPT_CAUSE_OUT  out  CAUSE_W  head exception cause
- OCCUPANCY  out  CNT_W  number of valid entries
- STALL_CNT  out  32  decode-stall cycle counter (Optional Feature)

Behaviour:
- Reset (RST=0 at posedge): rd_ptr=wr_ptr=0, count=0, every storage field zeroed. After reset: OUT_VALID=0, OCCUPANCY=0, all payload outputs 0, STALL_CNT=0, IN_READY=1 unless LOCK.
- Zero-on-empty: while OUT_VALID=0, every payload output is forced to 0 regardless of storage contents.
- Enqueue (enq) = IN_VALID && IN_READY. Dequeue (deq) = OUT_VALID && OUT_READY && !LOCK.
- Enqueue writes mem[wr_ptr] and advances wr_ptr modulo DEPTH. An entry enqueued at edge N is visible at the head no earlier than cycle N+1. No same-cycle bypass.
- Exception squash: if XCPT_IN=1 on enq, the entry stores PC_IN, INST=0, CTRL=0, XCPT=1 and XCPT_CAUSE_IN. Otherwise all inputs are stored verbatim.
- Dequeue advances rd_ptr modulo DEPTH.
- Simultaneous enq and deq: count is unchanged and both pointers advance.
- Full: count=DEPTH, so IN_READY=0 even if OUT_READY=1 that cycle (no pass-through).
- Empty: deq cannot occur; OUT_READY is ignored.
- Pointer wrap: DEPTH-1 → 0. Full/empty are derived from count, never from pointer equality alone.
- Priority per edge, highest first:
  1. RST=0
  2. FLUSH_P1: pointers=0, count=0, stored valid state lost; the input is dropped even if IN_VALID=1
  3. LOCK: hold all state, no enq/deq
  4. FLUSH_P2: same clear as P1, input dropped
  5. normal enq/deq
- IN_READY is combinational from count and LOCK only. It does not depend on the flush inputs; an entry offered during a flush counts as dropped by decode.
- OCCUPANCY equals count and is registered.
- Reset or flush mid-stream discards all entries with no partial state. The following cycle: OUT_VALID=0, OCCUPANCY=0.

Optional Feature:
- Macro: LATCH_DECODE_RR_STALL_CNT_EN.
- Defined: STALL_CNT is a 32-bit register. It increments (wrapping at 2^32) on each cycle with IN_VALID=1 && IN_READY=0. It is cleared by reset only; flushes do not clear it.
- Undefined: STALL_CNT is tied to 32'h0 and no counter logic is generated.

Test Plan:
- Reset then idle: RST=0 for 2 cycles, release → OUT_VALID=0, OCCUPANCY=0, PC_OUT=0, INST_OUT=0, IN_READY=1.
- Fill/drain, DEPTH=2, OUT_READY=0: enqueue PC 0x100 and 0x104 → OCCUPANCY=2, IN_READY=0. Then OUT_READY=1 → heads 0x100 then 0x104 in consecutive cycles, then OUT_VALID=0.
- Exception squash: enqueue PC 0x200, INST 0x00000013, CTRL 0xABCD, XCPT_IN=1, cause 64'd2 → head shows PC 0x200, INST 0, CTRL 0, XCPT_OUT=1, cause 2.
- Lock vs flush: 1 entry held, LOCK=1 and FLUSH_P2=1 → entry retained, OCCUPANCY=1. Then LOCK=1 and FLUSH_P1=1 → OCCUPANCY=0, OUT_VALID=0 next cycle.
- Wrap with streaming: DEPTH=4, continuous IN_VALID=1 and OUT_READY=1 for 10 entries with PC=0x1000+4i → outputs in order with no gaps after the first, OCCUPANCY stays 1.
- Stall counter (macro defined): hold full with IN_VALID=1 for 5 cycles → STALL_CNT=5. Assert FLUSH_P1 → STALL_CNT still 5. Macro undefined → STALL_CNT=0 throughout.

Source files
------------

// File: rtl/latch_decode_rr_fifo.sv
// latch_decode_rr_fifo
//   Decode -> register-read pipeline buffer. A DEPTH-entry circular FIFO with
//   valid/ready handshakes on both sides, a global LOCK, and a two-level flush.
//   FLUSH_P1 clears the buffer even under LOCK. FLUSH_P2 yields to LOCK.
//   An entry enqueued with XCPT_IN=1 keeps its PC and cause, and has its
//   instruction and control fields squashed to zero.
//
// Ports
//   CLK, RST                 clock, synchronous active-low reset
//   LOCK                     freeze all buffer state
//   FLUSH_P1 / FLUSH_P2      high / low priority flush
//   IN_VALID / IN_READY      decode-side handshake
//   PC_IN .. XCPT_CAUSE_IN   decoded entry payload
//   OUT_VALID / OUT_READY    RR-side handshake
//   PC_OUT .. XCPT_CAUSE_OUT head entry payload, zero while empty
//   OCCUPANCY                number of valid entries
//   STALL_CNT                cycles with IN_VALID=1 and IN_READY=0
//
// Build option
//   LATCH_DECODE_RR_STALL_CNT_EN : when defined, STALL_CNT is a live 32-bit
//   counter, cleared by reset only. When undefined, STALL_CNT is tied to zero.

module latch_decode_rr_fifo #(
  parameter int ADDR_W  = 40,
  parameter int INST_W  = 32,
  parameter int CTRL_W  = 16,
  parameter int CAUSE_W = 64,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LOCK,
  input  logic               FLUSH_P1,
  input  logic               FLUSH_P2,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [ADDR_W-1:0]  PC_IN,
  input  logic [INST_W-1:0]  INST_IN,
  input  logic [CTRL_W-1:0]  CTRL_IN,
  input  logic               XCPT_IN,
  input  logic [CAUSE_W-1:0] XCPT_CAUSE_IN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [ADDR_W-1:0]  PC_OUT,
  output logic [INST_W-1:0]  INST_OUT,
  output logic [CTRL_W-1:0]  CTRL_OUT,
  output logic               XCPT_OUT,
  output logic [CAUSE_W-1:0] XCPT_CAUSE_OUT,
  output logic [CNT_W-1:0]   OCCUPANCY,
  output logic [31:0]        STALL_CNT
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INST_W-1:0]  inst_mem  [DEPTH];
  logic [CTRL_W-1:0]  ctrl_mem  [DEPTH];
  logic               xcpt_mem  [DEPTH];
  logic [CAUSE_W-1:0] cause_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;

  // Full/empty come from the counter; equal pointers alone are ambiguous.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign IN_READY  = !full && !LOCK;
  assign OUT_VALID = !empty;
  assign OCCUPANCY = count;

  assign enq = IN_VALID && IN_READY;
  assign deq = OUT_VALID && OUT_READY && !LOCK;

  assign rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  assign wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

  // Stale storage is never exposed: the head reads as zero while empty.
  assign PC_OUT         = empty ? '0   : pc_mem[rd_ptr];
  assign INST_OUT       = empty ? '0   : inst_mem[rd_ptr];
  assign CTRL_OUT       = empty ? '0   : ctrl_mem[rd_ptr];
  assign XCPT_OUT       = empty ? 1'b0 : xcpt_mem[rd_ptr];
  assign XCPT_CAUSE_OUT = empty ? '0   : cause_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        inst_mem[i]  <= '0;
        ctrl_mem[i]  <= '0;
        xcpt_mem[i]  <= 1'b0;
        cause_mem[i] <= '0;
      end
    end else if (FLUSH_P1) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!LOCK) begin
      if (FLUSH_P2) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          pc_mem[wr_ptr]    <= PC_IN;
          inst_mem[wr_ptr]  <= XCPT_IN ? '0 : INST_IN;
          ctrl_mem[wr_ptr]  <= XCPT_IN ? '0 : CTRL_IN;
          xcpt_mem[wr_ptr]  <= XCPT_IN;
          cause_mem[wr_ptr] <= XCPT_CAUSE_IN;
          wr_ptr            <= wr_ptr_nxt;
        end
        if (deq) begin
          rd_ptr <= rd_ptr_nxt;
        end
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef LATCH_DECODE_RR_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Counts every refused offer, including those refused by LOCK; only reset clears it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (IN_VALID && !IN_READY) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign STALL_CNT = stall_cnt;
`else
  assign STALL_CNT = 32'h0;
`endif

endmodule
